// File: rtl/circular_buffer.sv
// Flit FIFO with first-word fall-through output and on/off upstream flow control.
// The flit type package is kept in this file so the block is self-contained.

package noc_params;
    localparam int X_W       = 4;
    localparam int Y_W       = 4;
    localparam int PAYLOAD_W = 22;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [X_W-1:0]       x_dest;
        logic [Y_W-1:0]       y_dest;
        logic [PAYLOAD_W-1:0] payload;
    } flit_Data_noVC;
endpackage

module circular_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE   = 8,
    parameter int OFF_THRESHOLD = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  flit_Data_noVC input_Data,
    input  logic          write_i,
    input  logic          read_i,
    output flit_Data_noVC output_Data,
    output logic          buf_empty,
    output logic          buf_full,
    output logic          buf_On_Off
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(BUFFER_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] OFF_LEVEL = CNT_W'(OFF_THRESHOLD);

    flit_Data_noVC    memory [BUFFER_SIZE];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             wr_en;
    logic             rd_en;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [CNT_W-1:0] free_slots;

    // Status flags come straight from the registered count, so they cannot
    // glitch with write_i/read_i.
    assign buf_empty  = (count == '0);
    assign buf_full   = (count == FULL_CNT);
    assign free_slots = FULL_CNT - count;
    assign buf_On_Off = (free_slots > OFF_LEVEL);

    // A full buffer still accepts a write when a read frees the head slot in
    // the same edge. An empty buffer never bypasses: the read is dropped.
    assign wr_en = write_i && (!buf_full || read_i);
    assign rd_en = read_i && !buf_empty;

    // Explicit wrap keeps non-power-of-two depths correct.
    assign rd_ptr_next = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
    assign wr_ptr_next = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;

    // Head flit falls through combinationally; zero when empty hides stale data.
    assign output_Data = buf_empty ? '0 : memory[rd_ptr];

    // Storage array: never reset, writes blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            memory[wr_ptr] <= input_Data;
        end
    end

    // Pointer and occupancy state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr_next;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr_next;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_circular_buffer.sv
// Scoreboard bench for circular_buffer: accepted writes are pushed to a queue
// and every accepted read is checked against the queue head.

module tb_circular_buffer;
    import noc_params::*;

    localparam int N  = 8;
    localparam int TH = 2;

    logic          clk;
    logic          rst_n;
    flit_Data_noVC input_Data;
    logic          write_i;
    logic          read_i;
    flit_Data_noVC output_Data;
    logic          buf_empty;
    logic          buf_full;
    logic          buf_On_Off;

    circular_buffer #(
        .BUFFER_SIZE   (N),
        .OFF_THRESHOLD (TH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_Data  (input_Data),
        .write_i     (write_i),
        .read_i      (read_i),
        .output_Data (output_Data),
        .buf_empty   (buf_empty),
        .buf_full    (buf_full),
        .buf_On_Off  (buf_On_Off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_count  = 0;
    int miscompare = 0;

    flit_Data_noVC model_q[$];
    int            model_rd = 0;
    int            model_wr = 0;
    int            serial   = 1;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompare++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic flit_Data_noVC mk(input flit_label_t l, input int n);
        flit_Data_noVC f;
        f.flit_label = l;
        f.x_dest     = 4'(n);
        f.y_dest     = 4'(n >> 4);
        f.payload    = 22'(n * 37 + 5);
        return f;
    endfunction

    function automatic flit_Data_noVC next_flit();
        flit_Data_noVC f;
        f = mk(BODY, serial);
        serial++;
        return f;
    endfunction

    // One clock cycle: drive just after negedge, check before the posedge,
    // update the model at the posedge, return at the following negedge.
    task automatic step(input logic w, input logic r, input flit_Data_noVC d);
        bit do_wr;
        bit do_rd;
        int sz;
        write_i    = w;
        read_i     = r;
        input_Data = d;
        #1;
        sz = model_q.size();
        chk("empty", 32'(buf_empty), 32'(sz == 0));
        chk("full", 32'(buf_full), 32'(sz == N));
        chk("on_off", 32'(buf_On_Off), 32'((N - sz) > TH));
        if (sz == 0) chk("out_zero", 32'(output_Data), 32'(0));
        else         chk("head", 32'(output_Data), 32'(model_q[0]));
        do_rd = rst_n && r && (sz > 0);
        do_wr = rst_n && w && ((sz < N) || r);
        @(posedge clk);
        if (do_rd) begin
            void'(model_q.pop_front());
            model_rd = (model_rd + 1) % N;
        end
        if (do_wr) begin
            model_q.push_back(d);
            model_wr = (model_wr + 1) % N;
        end
        @(negedge clk);
        $display("step w=%0b r=%0b din=%h -> count=%0d out=%h", w, r, d, model_q.size(), output_Data);
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, next_flit());
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0);
    endtask

    flit_Data_noVC fa, fb, fx;

    initial begin
        rst_n      = 1'b0;
        write_i    = 1'b0;
        read_i     = 1'b0;
        input_Data = '0;
        #3;
        chk("rst_empty", 32'(buf_empty), 32'(1));
        chk("rst_full", 32'(buf_full), 32'(0));
        chk("rst_on_off", 32'(buf_On_Off), 32'(1));
        chk("rst_out", 32'(output_Data), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic FWFT: write A then B, read shows A before the edge, B after.
        fa = '0;
        fa.flit_label = HEAD;
        fb = mk(TAIL, 8'h5A);
        step(1'b1, 1'b0, fa);
        step(1'b1, 1'b0, fb);
        step(1'b0, 1'b1, '0);
        chk("fwft_out_b", 32'(output_Data), 32'(fb));
        chk("fwft_count", 32'(dut.count), 32'(1));
        read_n(1);

        // Fill to full, try an ignored 9th write, then drain in order.
        write_n(N);
        chk("fill_full", 32'(buf_full), 32'(1));
        chk("fill_off", 32'(buf_On_Off), 32'(0));
        step(1'b1, 1'b0, mk(HEADTAIL, 8'hEE));
        chk("fill_ignored", 32'(dut.count), 32'(N));
        read_n(N);

        // Drain/wrap: pointers cross the end of the array.
        write_n(N);
        read_n(4);
        write_n(4);
        chk("wrap_wr_ptr", 32'(dut.wr_ptr), 32'(model_wr));
        read_n(N);
        chk("wrap_empty", 32'(buf_empty), 32'(1));
        chk("wrap_out", 32'(output_Data), 32'(0));

        // Simultaneous read/write while full, then while empty.
        write_n(N);
        step(1'b1, 1'b1, next_flit());
        chk("sim_full", 32'(buf_full), 32'(1));
        read_n(N);
        fx = mk(HEAD, 8'hC3);
        step(1'b1, 1'b1, fx);
        chk("sim_empty_count", 32'(dut.count), 32'(1));
        chk("sim_empty_out", 32'(output_Data), 32'(fx));
        read_n(1);

        // Underflow: reads while empty change nothing.
        read_n(3);
        chk("uf_rd_ptr", 32'(dut.rd_ptr), 32'(model_rd));
        chk("uf_wr_ptr", 32'(dut.wr_ptr), 32'(model_wr));
        chk("uf_empty", 32'(buf_empty), 32'(1));

        // Async reset between edges with five flits stored.
        write_n(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_empty", 32'(buf_empty), 32'(1));
        chk("ar_on_off", 32'(buf_On_Off), 32'(1));
        chk("ar_out", 32'(output_Data), 32'(0));
        chk("ar_full", 32'(buf_full), 32'(0));
        model_q.delete();
        model_rd = 0;
        model_wr = 0;
        @(negedge clk);
        step(1'b1, 1'b0, next_flit());
        step(1'b0, 1'b1, '0);
        chk("ar_held_count", 32'(dut.count), 32'(0));
        rst_n = 1'b1;
        fx = mk(TAIL, 8'h77);
        step(1'b1, 1'b0, fx);
        chk("post_rst_write", 32'(output_Data), 32'(fx));
        read_n(1);
        chk("final_empty", 32'(buf_empty), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
